// File: rtl/uart_reg_bridge_pkg.sv
// Shared types and byte codes for the UART register bridge: FSM states,
// command/response bytes and a counter-width helper.
package uart_reg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EXEC,
        ST_WAIT_RD,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NACK  = 8'h15;

    // Bits needed to count 0..limit-1, never less than one bit.
    function automatic int unsigned count_width(input int unsigned limit);
        int unsigned width;
        width = $clog2(limit);
        if (width < 1) width = 1;
        return width;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Signal bundle between the bridge and its byte source, register block and tx FIFO.
// The bridge uses the slave view; whatever drives the bridge uses the master view.
interface uart_reg_bridge_if #(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned VALUE_WORDS = 4
);
    localparam int unsigned VALUE_WIDTH = WORD_WIDTH * VALUE_WORDS;

    logic [WORD_WIDTH-1:0]  i_data;
    logic                   i_dv;
    logic [WORD_WIDTH-1:0]  o_addr;
    logic [VALUE_WIDTH-1:0] o_w_value;
    logic                   o_w_en;
    logic                   o_r_en;
    logic [VALUE_WIDTH-1:0] i_r_value;
    logic                   i_r_valid;
    logic [WORD_WIDTH-1:0]  o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;
    logic                   o_busy;
    logic                   o_overrun;

    modport slave (
        input  i_data, i_dv, i_r_value, i_r_valid, i_tx_ready,
        output o_addr, o_w_value, o_w_en, o_r_en, o_tx_data, o_tx_valid, o_busy, o_overrun
    );

    modport master (
        output i_data, i_dv, i_r_value, i_r_valid, i_tx_ready,
        input  o_addr, o_w_value, o_w_en, o_r_en, o_tx_data, o_tx_valid, o_busy, o_overrun
    );

endinterface

// File: rtl/uart_reg_bridge_timeout_counter.sv
// Saturating cycle counter: expired goes high LIMIT cycles after the last clear
// and stays high until the next clear.
module uart_reg_bridge_timeout_counter
    import uart_reg_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = count_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Framed byte-command bridge: parses write/read frames from a byte stream, strobes
// the register block and returns ACK/NACK or read data as a valid/ready byte stream.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned VALUE_WORDS   = 4,
    parameter int unsigned REG_DEPTH     = 16,
    parameter int unsigned LITTLE_ENDIAN = 0,
    parameter int unsigned BYTE_TIMEOUT  = 1000000,
    parameter int unsigned RD_TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             i_reset_n,
    uart_reg_bridge_if.slave bus
);
    localparam int unsigned VALUE_WIDTH = WORD_WIDTH * VALUE_WORDS;
    localparam int unsigned WCW         = count_width(VALUE_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(VALUE_WORDS - 1);

    localparam logic [WORD_WIDTH-1:0] CMD_W_B = WORD_WIDTH'(CMD_W);
    localparam logic [WORD_WIDTH-1:0] CMD_R_B = WORD_WIDTH'(CMD_R);
    localparam logic [WORD_WIDTH-1:0] ACK_B   = WORD_WIDTH'(ACK);
    localparam logic [WORD_WIDTH-1:0] NACK_B  = WORD_WIDTH'(NACK);

    state_t                 state;
    logic [WORD_WIDTH-1:0]  cmd;
    logic                   addr_err;
    logic [WCW-1:0]         word_cnt;
    logic [VALUE_WIDTH-1:0] rx_shift;
    logic [VALUE_WIDTH-1:0] rx_next;
    logic [VALUE_WIDTH-1:0] tx_shift;
    logic [WCW-1:0]         tx_left;
    logic                   in_frame;
    logic                   byte_expired;
    logic                   rd_expired;

    // Word order on the wire: big-endian sends the most-significant word first.
    function automatic logic [WORD_WIDTH-1:0] head_word(input logic [VALUE_WIDTH-1:0] v);
        if (LITTLE_ENDIAN != 0) return v[WORD_WIDTH-1:0];
        else                    return v[VALUE_WIDTH-1 -: WORD_WIDTH];
    endfunction

    function automatic logic [VALUE_WIDTH-1:0] drop_word(input logic [VALUE_WIDTH-1:0] v);
        if (LITTLE_ENDIAN != 0) return v >> WORD_WIDTH;
        else                    return v << WORD_WIDTH;
    endfunction

    always_comb begin
        if (LITTLE_ENDIAN != 0) begin
            rx_next = (rx_shift >> WORD_WIDTH) |
                      (VALUE_WIDTH'(bus.i_data) << (VALUE_WIDTH - WORD_WIDTH));
        end else begin
            rx_next = (rx_shift << WORD_WIDTH) | VALUE_WIDTH'(bus.i_data);
        end
    end

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA);

    uart_reg_bridge_timeout_counter #(
        .LIMIT(BYTE_TIMEOUT)
    ) u_byte_timer (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .clear    (bus.i_dv || !in_frame),
        .enable   (1'b1),
        .expired  (byte_expired)
    );

    // Counts from the o_r_en cycle, so expiry lands RD_TIMEOUT cycles after the strobe.
    uart_reg_bridge_timeout_counter #(
        .LIMIT(RD_TIMEOUT)
    ) u_rd_timer (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .clear    (state != ST_WAIT_RD),
        .enable   (1'b1),
        .expired  (rd_expired)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            cmd            <= '0;
            addr_err       <= 1'b0;
            word_cnt       <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            tx_left        <= '0;
            bus.o_addr     <= '0;
            bus.o_w_value  <= '0;
            bus.o_w_en     <= 1'b0;
            bus.o_r_en     <= 1'b0;
            bus.o_tx_data  <= '0;
            bus.o_tx_valid <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_overrun  <= 1'b0;
        end else begin
            bus.o_w_en <= 1'b0;
            bus.o_r_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.i_dv) begin
                        cmd        <= bus.i_data;
                        state      <= ST_ADDR;
                        bus.o_busy <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (bus.i_dv) begin
                        bus.o_addr <= bus.i_data;
                        addr_err   <= (32'(bus.i_data) >= REG_DEPTH);
                        word_cnt   <= '0;
                        if (cmd == CMD_W_B) begin
                            state <= ST_DATA;
                        end else if (cmd == CMD_R_B) begin
                            state      <= ST_EXEC;
                            bus.o_r_en <= (32'(bus.i_data) < REG_DEPTH);
                        end else begin
                            state          <= ST_RESP;
                            bus.o_tx_data  <= NACK_B;
                            bus.o_tx_valid <= 1'b1;
                            tx_left        <= '0;
                        end
                    end else if (byte_expired) begin
                        state      <= ST_IDLE;
                        bus.o_busy <= 1'b0;
                    end
                end

                // Bad-address writes still swallow their data bytes so the stream stays framed.
                ST_DATA: begin
                    if (bus.i_dv) begin
                        rx_shift <= rx_next;
                        word_cnt <= word_cnt + WCW'(1);
                        if (word_cnt == LAST_WORD) begin
                            state <= ST_EXEC;
                            if (!addr_err) begin
                                bus.o_w_en    <= 1'b1;
                                bus.o_w_value <= rx_next;
                            end
                        end
                    end else if (byte_expired) begin
                        state      <= ST_IDLE;
                        bus.o_busy <= 1'b0;
                    end
                end

                ST_EXEC: begin
                    if ((cmd == CMD_R_B) && !addr_err) begin
                        state <= ST_WAIT_RD;
                    end else begin
                        state          <= ST_RESP;
                        bus.o_tx_data  <= addr_err ? NACK_B : ACK_B;
                        bus.o_tx_valid <= 1'b1;
                        tx_left        <= '0;
                    end
                end

                ST_WAIT_RD: begin
                    if (bus.i_r_valid) begin
                        state          <= ST_RESP;
                        bus.o_tx_data  <= head_word(bus.i_r_value);
                        bus.o_tx_valid <= 1'b1;
                        tx_shift       <= drop_word(bus.i_r_value);
                        tx_left        <= LAST_WORD;
                    end else if (rd_expired) begin
                        state          <= ST_RESP;
                        bus.o_tx_data  <= NACK_B;
                        bus.o_tx_valid <= 1'b1;
                        tx_left        <= '0;
                    end
                end

                ST_RESP: begin
                    if (bus.i_tx_ready) begin
                        if (tx_left == '0) begin
                            state          <= ST_IDLE;
                            bus.o_tx_valid <= 1'b0;
                            bus.o_busy     <= 1'b0;
                        end else begin
                            bus.o_tx_data <= head_word(tx_shift);
                            tx_shift      <= drop_word(tx_shift);
                            tx_left       <= tx_left - WCW'(1);
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase

            if (bus.i_dv && ((state == ST_EXEC) || (state == ST_WAIT_RD) || (state == ST_RESP))) begin
                bus.o_overrun <= 1'b1;
            end
        end
    end

endmodule
